data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Single-port arbiter and sequencer for data_mem. It shares the data memory among NREQ requesters:
//  req0 = CPU load/store, req1 = stack push/pull, req2 = link save/restore for jump/return.
//  Each granted transaction is expanded into data_mem's timing: read settle, or mode held high for a write.
//  A 1-cycle ack closes every transaction. This replaces the ad-hoc data_adrs/data_mode driving in the core FSM.
// PARAMETERS
//  NREQ     3   number of requesters (2..4)
//  ADDR_W   6   data_mem address width
//  DATA_W   8   data word width
//  RD_LAT   2   cycles from address applied to data_mem out valid (>=1)
//  WR_HOLD  3   cycles mem_mode held high per write (>=1)
// PORTS
//  clk       in   1             system clock, all logic on posedge
//  rst_n     in   1             asynchronous active-low reset
//  req       in   NREQ          per-requester request level, held until ack
//  we        in   NREQ          per-requester 1=write 0=read, valid while req
//  adrs      in   NREQ*ADDR_W   per-requester address, slice i = requester i
//  wdata     in   NREQ*DATA_W   per-requester write data, slice i
//  gnt       out  NREQ          one-hot owner of current transaction
//  ack       out  NREQ          one-hot 1-cycle completion pulse
//  rdata     out  DATA_W        read result, valid in ack cycle, held until next read completes
//  mem_adrs  out  ADDR_W        to data_mem adrs
//  mem_mode  out  1             to data_mem mode (1=write)
//  mem_data  out  DATA_W        to data_mem data
//  mem_out   in   DATA_W        from data_mem out
//  busy      out  1             high in any state but IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; gnt, ack, mem_mode, busy=0; mem_adrs, mem_data, rdata=0; rr_ptr=0. Takes effect immediately.
//  Reset mid-write: mem_mode drops without waiting for the clock. The partial write is abandoned and no ack is issued.
//  FSM states are IDLE, ACCESS and DONE.
//   IDLE: if any req is high, pick winner i, register gnt[i], and latch adrs_i into mem_adrs and wdata_i into mem_data.
//    Latch the winner's we into the op type; mem_mode=we_i. Reset cnt=1, go to ACCESS. With no req high, stay in IDLE with outputs quiet.
//   ACCESS read: hold mem_adrs for RD_LAT cycles (cnt==RD_LAT), then capture rdata<=mem_out and go to DONE.
//   ACCESS write: mem_mode=1 for exactly WR_HOLD cycles. On cnt==WR_HOLD, mem_mode<=0 and go to DONE.
//   DONE: ack[i]=1 for this single cycle. Clear gnt, go to IDLE.
//  Latency from the IDLE edge that grants: read ack in cycle RD_LAT+1 (3 with defaults); write ack in cycle WR_HOLD+1 (4 with defaults).
//  Turnaround: a new grant is possible only from IDLE, so there is at least one idle cycle between transactions.
//   Back-to-back throughput is 1 read per RD_LAT+2 cycles.
//  Requester contract: drop req in the cycle after ack, or keep it high to queue another request. No protocol timeout.
//  Arbitration is round-robin. Search order starts at rr_ptr. After a grant to i, rr_ptr<=(i+1) mod NREQ, wrapping NREQ-1 to 0.
//  Simultaneous requests: exactly one grant per IDLE cycle. Losers stay pending without error.
//  req dropped while granted: the transaction still completes and ack still pulses. adrs, we and wdata are not re-sampled after grant.
//  Inputs of the owning requester may change freely after the grant.
//  gnt and ack are always one-hot or zero. busy = (state!=IDLE).
// CONFIGURATION
//  DMARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is removed and req0 can starve the others.
//  DMARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1 Reset: rst_n=0 mid-write (cycle 2 of hold) -> mem_mode=0 same cycle; gnt=ack=0, busy=0; no ack after release.
//  2 Single write: req=001, we=001, adrs0=5, wdata0=8'hA5 -> mem_mode high 3 cycles at adrs 5. ack=001 in cycle 4.
//    Then a read of adrs 5 -> rdata=8'hA5 with ack=001 in cycle 3.
//  3 Contention: req=111 held, all reads -> gnt order 001,010,100,001 (RR). With DMARB_FIXED_PRIO_EN -> 001 every time.
//  4 Wrap: rr_ptr=2, req=101 -> grant 100 first, then 001.
//  5 Abort: req1 (write adrs 31, 8'h3C) dropped after grant -> write completes, ack=010; mem[31]=8'h3C.
//  6 Hold: rdata after a read of 8'h7E stays 8'h7E across a following write and the ack.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Single-port arbiter and sequencer for data_mem. Shares the data memory
//   among NREQ requesters (0: CPU load/store, 1: stack push/pull,
//   2: link save/restore). A grant latches the winner's address, write data
//   and operation type. A read then holds the address for RD_LAT cycles
//   before capturing mem_out. A write holds mem_mode high for WR_HOLD cycles.
//   A one-cycle ack closes every transaction.
//
//   Optional build macro: DMARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest requesting index wins
//     undefined -> round-robin starting at rr_ptr (default)
//
// Ports
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   req       per-requester request level, held until ack
//   we        per-requester write flag (1=write), valid while req
//   adrs      packed per-requester address, slice i = requester i
//   wdata     packed per-requester write data, slice i = requester i
//   gnt       one-hot owner of the current transaction
//   ack       one-hot single-cycle completion pulse
//   rdata     last read result, held until the next read completes
//   mem_adrs  data_mem address
//   mem_mode  data_mem mode (1=write)
//   mem_data  data_mem write data
//   mem_out   data_mem read data
//   busy      high in any state but IDLE
module data_mem_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned WR_HOLD = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] adrs,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      mem_adrs,
  output logic                   mem_mode,
  output logic [DATA_W-1:0]      mem_data,
  input  logic [DATA_W-1:0]      mem_out,
  output logic                   busy
);

  localparam int unsigned CNT_MAX = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W   = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_adrs_q, mem_adrs_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_mode_q, mem_mode_d;
  logic              op_we_q, op_we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              any_req;
  logic [PTR_W-1:0]  win_idx;

`ifndef DMARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  int unsigned       scan_idx;
`endif

  // Winner selection
  always_comb begin
    any_req = |req;
    win_idx = '0;
`ifdef DMARB_FIXED_PRIO_EN
    // Descending scan: the last hit is the lowest requesting index.
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (req[PTR_W'(k - 32'd1)]) begin
        win_idx = PTR_W'(k - 32'd1);
      end
    end
`else
    scan_idx = 0;
    // Offsets scanned high to low so the final hit is the first requester
    // found at or after rr_ptr in round-robin order.
    for (int unsigned k = NREQ; k > 0; k--) begin
      scan_idx = (32'(rr_ptr_q) + k - 32'd1) % NREQ;
      if (req[scan_idx[PTR_W-1:0]]) begin
        win_idx = scan_idx[PTR_W-1:0];
      end
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    mem_adrs_d = mem_adrs_q;
    mem_data_d = mem_data_q;
    mem_mode_d = mem_mode_q;
    op_we_d    = op_we_q;
    cnt_d      = cnt_q;
`ifndef DMARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          mem_adrs_d     = adrs[32'(win_idx)*ADDR_W +: ADDR_W];
          mem_data_d     = wdata[32'(win_idx)*DATA_W +: DATA_W];
          op_we_d        = we[win_idx];
          mem_mode_d     = we[win_idx];
          cnt_d          = CNT_W'(1);
          state_d        = S_ACCESS;
`ifndef DMARB_FIXED_PRIO_EN
          rr_ptr_d       = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
`endif
        end
      end

      S_ACCESS: begin
        if (op_we_q) begin
          if (cnt_q == CNT_W'(WR_HOLD)) begin
            mem_mode_d = 1'b0;
            ack_d      = gnt_q;
            state_d    = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q == CNT_W'(RD_LAT)) begin
            rdata_d = mem_out;
            ack_d   = gnt_q;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        // ack_q is high for this one cycle; ack_d defaults back to zero.
        gnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      mem_adrs_q <= '0;
      mem_data_q <= '0;
      mem_mode_q <= 1'b0;
      op_we_q    <= 1'b0;
      cnt_q      <= '0;
`ifndef DMARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      mem_adrs_q <= mem_adrs_d;
      mem_data_q <= mem_data_d;
      mem_mode_q <= mem_mode_d;
      op_we_q    <= op_we_d;
      cnt_q      <= cnt_d;
`ifndef DMARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign mem_adrs = mem_adrs_q;
  assign mem_data = mem_data_q;
  assign mem_mode = mem_mode_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model and a shadow memory.
module tb_data_mem_arbiter;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned WR_HOLD = 3;
  localparam int unsigned NCYC    = 1500;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req   = '0;
  logic [NREQ-1:0]        we    = '0;
  logic [NREQ*ADDR_W-1:0] adrs  = '0;
  logic [NREQ*DATA_W-1:0] wdata = '0;
  logic [NREQ-1:0]        gnt, ack;
  logic [DATA_W-1:0]      rdata, mem_data, mem_out;
  logic [ADDR_W-1:0]      mem_adrs;
  logic                   mem_mode, busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] shadow [64];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .WR_HOLD(WR_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .adrs    (adrs),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .rdata   (rdata),
    .mem_adrs(mem_adrs),
    .mem_mode(mem_mode),
    .mem_data(mem_data),
    .mem_out (mem_out),
    .busy    (busy)
  );

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {2'b00, a} * 8'd29 + 8'h5B;
  endfunction

  logic [DATA_W-1:0] mem [64];
  logic [63:0]       written   = '0;
  logic [ADDR_W-1:0] prev_adrs = '0;
  logic [DATA_W-1:0] mem_val;

  always @(posedge clk) begin
    if (mem_mode) begin
      mem[mem_adrs]     <= mem_data;
      written[mem_adrs] <= 1'b1;
    end
    prev_adrs <= mem_adrs;
  end

  always_comb begin
    mem_val = written[mem_adrs] ? mem[mem_adrs] : pat(mem_adrs);
    mem_out = (mem_adrs == prev_adrs) ? mem_val : ~mem_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[i]                      = 1'b1;
    we[i]                       = w;
    adrs[i*ADDR_W +: ADDR_W]    = a;
    wdata[i*DATA_W +: DATA_W]   = d;
  endtask

  task automatic wait_ack(output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack === '0 && n < 16);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic seen_ack;
    rst_n = 1'b0;
    req = '0;
    repeat (2) tick();
    checks++;
    if ({gnt, ack, busy, mem_mode} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b ack=%b busy=%b mode=%b expected all 0", gnt, ack, busy, mem_mode);
    end
    checks++;
    if ({mem_adrs, mem_data, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: adrs=%h data=%h rdata=%h expected 0", mem_adrs, mem_data, rdata);
    end
    rst_n = 1'b1;
    tick();
    set_req(0, 1'b1, 6'd9, 8'h55);
    tick();
    checks++;
    if (mem_mode !== 1'b1 || gnt !== 3'b001) begin
      errors++;
      $display("FAIL reset_pre_write: mode=%b gnt=%b expected 1 001", mem_mode, gnt);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_mode: got %b expected 0", mem_mode);
    end
    checks++;
    if ({gnt, ack, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async_ctrl: gnt=%b ack=%b busy=%b expected 0", gnt, ack, busy);
    end
    req = '0;
    tick();
    rst_n = 1'b1;
    seen_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_ack = seen_ack | (|ack) | busy;
    end
    checks++;
    if (seen_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_ack: ack/busy seen=%b expected 0", seen_ack);
    end
    shadow[9] = 8'h55;
  endtask

  task automatic test_single_write();
    logic [NREQ-1:0] exp_ack;
    set_req(0, 1'b1, 6'd5, 8'hA5);
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_ack = (c == 4) ? 3'b001 : 3'b000;
      checks++;
      if (mem_mode !== 1'(c <= 3)) begin
        errors++;
        $display("FAIL write_mode c%0d: got %b expected %b", c, mem_mode, 1'(c <= 3));
      end
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL write_ack c%0d: got %b expected %b", c, ack, exp_ack);
      end
      if (c <= 4) begin
        checks++;
        if (mem_adrs !== 6'd5) begin
          errors++;
          $display("FAIL write_adrs c%0d: got %0d expected 5", c, mem_adrs);
        end
      end
      if (c == 4) req[0] = 1'b0;
    end
    shadow[5] = 8'hA5;
    set_req(0, 1'b0, 6'd5, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp_ack = (c == 3) ? 3'b001 : 3'b000;
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL read_ack c%0d: got %b expected %b", c, ack, exp_ack);
      end
      if (c == 3) begin
        checks++;
        if (rdata !== 8'hA5) begin
          errors++;
          $display("FAIL read_rdata: got %h expected a5", rdata);
        end
        req[0] = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_contention();
    int unsigned     n;
    int unsigned     exp_i [4];
    logic [NREQ-1:0] e;
`ifdef DMARB_FIXED_PRIO_EN
    exp_i = '{0, 0, 0, 0};
`else
    exp_i = '{0, 1, 2, 0};
`endif
    pulse_reset();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDR_W'(10 + i), 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      e = 3'b001 << exp_i[k];
      checks++;
      if (ack !== e) begin
        errors++;
        $display("FAIL contention_ack %0d: got %b expected %b", k, ack, e);
      end
      checks++;
      if (gnt !== e) begin
        errors++;
        $display("FAIL contention_gnt %0d: got %b expected %b", k, gnt, e);
      end
      checks++;
      if (rdata !== shadow[10 + exp_i[k]]) begin
        errors++;
        $display("FAIL contention_rdata %0d: got %h expected %h", k, rdata, shadow[10 + exp_i[k]]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    int unsigned n, fi, si;
`ifdef DMARB_FIXED_PRIO_EN
    fi = 0; si = 2;
`else
    fi = 2; si = 0;
`endif
    set_req(1, 1'b0, 6'd40, 8'h00);
    wait_ack(n);
    checks++;
    if (ack !== 3'b010) begin
      errors++;
      $display("FAIL wrap_setup_ack: got %b expected 010", ack);
    end
    req[1] = 1'b0;
    set_req(0, 1'b0, 6'd41, 8'h00);
    set_req(2, 1'b0, 6'd42, 8'h00);
    wait_ack(n);
    checks++;
    if (ack !== (3'b001 << fi)) begin
      errors++;
      $display("FAIL wrap_first: got %b expected %b", ack, 3'b001 << fi);
    end
    checks++;
    if (rdata !== shadow[41 + fi / 2]) begin
      errors++;
      $display("FAIL wrap_first_rdata: got %h expected %h", rdata, shadow[41 + fi / 2]);
    end
    req[fi] = 1'b0;
    wait_ack(n);
    checks++;
    if (ack !== (3'b001 << si)) begin
      errors++;
      $display("FAIL wrap_second: got %b expected %b", ack, 3'b001 << si);
    end
    checks++;
    if (rdata !== shadow[41 + si / 2]) begin
      errors++;
      $display("FAIL wrap_second_rdata: got %h expected %h", rdata, shadow[41 + si / 2]);
    end
    req[si] = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int unsigned n;
    set_req(1, 1'b1, 6'd31, 8'h3C);
    tick();
    tick();
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL abort_gnt: got %b expected 010", gnt);
    end
    req[1] = 1'b0;
    we[1]  = 1'b0;
    adrs[1*ADDR_W +: ADDR_W]  = 6'd0;
    wdata[1*DATA_W +: DATA_W] = 8'hFF;
    wait_ack(n);
    checks++;
    if (ack !== 3'b010) begin
      errors++;
      $display("FAIL abort_ack: got %b expected 010", ack);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL abort_latency: ack after %0d further cycles expected 2", n);
    end
    shadow[31] = 8'h3C;
    set_req(0, 1'b0, 6'd31, 8'h00);
    wait_ack(n);
    checks++;
    if (rdata !== 8'h3C || ack !== 3'b001) begin
      errors++;
      $display("FAIL abort_readback: rdata=%h ack=%b expected 3c 001", rdata, ack);
    end
    req[0] = 1'b0;
  endtask

  task automatic test_hold();
    int unsigned     n;
    logic [NREQ-1:0] exp_ack;
    set_req(2, 1'b1, 6'd20, 8'h7E);
    wait_ack(n);
    req[2] = 1'b0;
    shadow[20] = 8'h7E;
    set_req(2, 1'b0, 6'd20, 8'h00);
    wait_ack(n);
    checks++;
    if (rdata !== 8'h7E || ack !== 3'b100) begin
      errors++;
      $display("FAIL hold_read: rdata=%h ack=%b expected 7e 100", rdata, ack);
    end
    req[2] = 1'b0;
    set_req(0, 1'b1, 6'd21, 8'h11);
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_ack = (c == 5) ? 3'b001 : 3'b000;
      checks++;
      if (rdata !== 8'h7E) begin
        errors++;
        $display("FAIL hold_rdata c%0d: got %h expected 7e", c, rdata);
      end
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL hold_ack c%0d: got %b expected %b", c, ack, exp_ack);
      end
      if (c == 5) req[0] = 1'b0;
    end
    shadow[21] = 8'h11;
  endtask

  task automatic test_random();
    int                own;
    int unsigned       k, g, ack_cyc, w, start, idx, rr;
    logic              own_we, active, is_ack, idle_now, found;
    logic [ADDR_W-1:0] own_a;
    logic [DATA_W-1:0] own_d, last_rd;
    logic [NREQ-1:0]   oh, e_gnt, e_ack;
    req = '0;
    pulse_reset();
    own = -1; rr = 0; k = 0; g = 0; ack_cyc = 0; w = 0;
    own_we = 1'b0; own_a = '0; own_d = '0; last_rd = '0;
    for (int unsigned t = 0; t < NCYC; t++) begin
      tick();
      k++;
      active = (own >= 0) && (k >= g);
      oh = '0;
      if (own >= 0) oh[own] = 1'b1;
      is_ack = active && (k == ack_cyc);
      if (is_ack) begin
        if (own_we) shadow[own_a] = own_d;
        else        last_rd = shadow[own_a];
      end
      e_gnt = active ? oh : '0;
      e_ack = is_ack ? oh : '0;
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL rand_gnt cyc%0d: got %b expected %b", k, gnt, e_gnt);
      end
      checks++;
      if (ack !== e_ack) begin
        errors++;
        $display("FAIL rand_ack cyc%0d: got %b expected %b", k, ack, e_ack);
      end
      checks++;
      if (busy !== active) begin
        errors++;
        $display("FAIL rand_busy cyc%0d: got %b expected %b", k, busy, active);
      end
      checks++;
      if (mem_mode !== (active && own_we && k < ack_cyc)) begin
        errors++;
        $display("FAIL rand_mode cyc%0d: got %b expected %b", k, mem_mode, active && own_we && k < ack_cyc);
      end
      checks++;
      if (rdata !== last_rd) begin
        errors++;
        $display("FAIL rand_rdata cyc%0d: got %h expected %h", k, rdata, last_rd);
      end
      if (active) begin
        checks++;
        if (mem_adrs !== own_a) begin
          errors++;
          $display("FAIL rand_adrs cyc%0d: got %h expected %h", k, mem_adrs, own_a);
        end
        if (own_we) begin
          checks++;
          if (mem_data !== own_d) begin
            errors++;
            $display("FAIL rand_wdata cyc%0d: got %h expected %h", k, mem_data, own_d);
          end
        end
      end

      idle_now = (own < 0);
      if (is_ack) begin
        if (req[own] && t + 40 < NCYC && $urandom_range(0, 1) == 1)
          set_req(own, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
        else
          req[own] = 1'b0;
        own = -1;
      end

      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!req[i] && int'(i) != own && t + 40 < NCYC && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
      end
      if (own >= 0 && active && $urandom_range(0, 7) == 0) begin
        we[own] = ~we[own];
        adrs[own*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
        wdata[own*DATA_W +: DATA_W] = DATA_W'($urandom);
        if ($urandom_range(0, 3) == 0) req[own] = 1'b0;
      end

      if (idle_now && req !== '0) begin
`ifdef DMARB_FIXED_PRIO_EN
        start = 0;
`else
        start = rr;
`endif
        found = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
          idx = (start + j) % NREQ;
          if (!found && req[idx]) begin
            w = idx;
            found = 1'b1;
          end
        end
        own     = int'(w);
        g       = k + 1;
        own_we  = we[w];
        own_a   = adrs[w*ADDR_W +: ADDR_W];
        own_d   = wdata[w*DATA_W +: DATA_W];
        ack_cyc = g + (own_we ? WR_HOLD : RD_LAT);
        rr      = (w + 1) % NREQ;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) shadow[a] = pat(6'(a));
    test_reset();
    test_single_write();
    test_contention();
    test_wrap();
    test_abort();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
